// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32I pipeline types and scoreboard helpers
// Contents: opcode_t, alu_op_t, REG_ZERO, latency_cd_w() countdown width helper.
package rv_pipe_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  localparam int REG_ZERO = 0;

  // Countdown must hold LOAD_LATENCY-1; keep at least one bit.
  function automatic int latency_cd_w(input int load_latency);
    return (load_latency <= 2) ? 1 : $clog2(load_latency);
  endfunction

endpackage

// File: rtl/rv_hazard_scoreboard_if.sv
// rtl/rv_hazard_scoreboard_if.sv - ID-stage handshake between decoder and scoreboard
// Signals: id_valid, id_rs1/_used, id_rs2/_used, id_rd, id_reg_write, id_is_load,
//          ex_ready (decoder side) and id_stall, id_issue (scoreboard side).
interface rv_hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_is_load;
  logic                  ex_ready;
  logic                  id_stall;
  logic                  id_issue;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_reg_write, id_is_load, ex_ready,
    input  id_stall, id_issue
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_reg_write, id_is_load, ex_ready,
    output id_stall, id_issue
  );
endinterface

// File: rtl/rv_sb_entry.sv
// rtl/rv_sb_entry.sv - one architectural register's pending count and ready countdown
// Ports: clk, reset_n; issue_i/issue_cd_i (new writer), wb_i, kill_i (retire/squash);
//        pend_cnt_o, ready_cd_o (state), underflow_o (retire/kill with nothing pending).
module rv_sb_entry #(
  parameter int CNT_W = 2,
  parameter int CD_W  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_i,
  input  logic [CD_W-1:0]  issue_cd_i,
  input  logic             wb_i,
  input  logic             kill_i,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic [CD_W-1:0]  ready_cd_o,
  output logic             underflow_o
);
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic [CD_W-1:0]  ready_cd_q, ready_cd_d;
  logic [CNT_W:0]   avail;
  logic [CNT_W:0]   dec;

  always_comb begin
    // Same-cycle issue counts as available before wb/kill are subtracted.
    avail       = (CNT_W+1)'(pend_cnt_q) + (CNT_W+1)'(issue_i);
    dec         = (CNT_W+1)'(wb_i) + (CNT_W+1)'(kill_i);
    underflow_o = 1'b0;
    if (dec > avail) begin
      pend_cnt_d  = '0;
      underflow_o = 1'b1;
    end else begin
      pend_cnt_d  = CNT_W'(avail - dec);
    end

    // Youngest writer governs: a reload wins over both a kill clear and decay.
    ready_cd_d = ready_cd_q;
    if (issue_i) begin
      ready_cd_d = issue_cd_i;
    end else if (kill_i && pend_cnt_d == '0) begin
      ready_cd_d = '0;
    end else if (ready_cd_q != '0) begin
      ready_cd_d = ready_cd_q - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_cnt_q <= '0;
      ready_cd_q <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      ready_cd_q <= ready_cd_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;
  assign ready_cd_o = ready_cd_q;
endmodule

// File: rtl/rv_hazard_scoreboard.sv
// rtl/rv_hazard_scoreboard.sv - ID-stage register scoreboard with stall generation
// Ports: clk, reset_n; id_if (slave: ID operands/dest, ex_ready -> id_stall, id_issue);
//        wb_valid/wb_rd (writeback), kill_valid/kill_rd (squash);
//        sb_error (sticky bookkeeping error), stall_cycles (saturating stall count).
module rv_hazard_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int ALU_LATENCY  = 1,
  parameter int LOAD_LATENCY = 2,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rv_hazard_scoreboard_if.slave id_if,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  kill_valid,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic                  sb_error,
  output logic [STAT_WIDTH-1:0] stall_cycles
);
  localparam int NREG  = 2**REG_ADDR_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int CD_W  = latency_cd_w(LOAD_LATENCY);
  localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

  logic [CNT_W-1:0] pend_cnt [NREG];
  logic [CD_W-1:0]  ready_cd [NREG];
  logic [NREG-1:0]  entry_err;

  logic             rs1_haz, rs2_haz, struct_haz, stall, issue, issue_wr;
  logic [CD_W-1:0]  issue_cd;

  logic                  sb_error_q, sb_error_d;
  logic [STAT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  // x0 is never tracked; its slot reads as idle.
  assign pend_cnt[0]  = '0;
  assign ready_cd[0]  = '0;
  assign entry_err[0] = 1'b0;

  always_comb begin
    rs1_haz    = id_if.id_rs1_used && (id_if.id_rs1 != RZ) && (ready_cd[id_if.id_rs1] != '0);
    rs2_haz    = id_if.id_rs2_used && (id_if.id_rs2 != RZ) && (ready_cd[id_if.id_rs2] != '0);
    struct_haz = id_if.id_reg_write && (id_if.id_rd != RZ) &&
                 (pend_cnt[id_if.id_rd] == CNT_W'(MAX_INFLIGHT));
    stall      = id_if.id_valid && (rs1_haz || rs2_haz || struct_haz);
    issue      = id_if.id_valid && !stall && id_if.ex_ready;
    issue_wr   = issue && id_if.id_reg_write && (id_if.id_rd != RZ);
    issue_cd   = id_if.id_is_load ? CD_W'(LOAD_LATENCY - 1) : CD_W'(ALU_LATENCY - 1);
  end

  assign id_if.id_stall = stall;
  assign id_if.id_issue = issue;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    rv_sb_entry #(
      .CNT_W (CNT_W),
      .CD_W  (CD_W)
    ) u_entry (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_i     (issue_wr && (id_if.id_rd == REG_ADDR_W'(r))),
      .issue_cd_i  (issue_cd),
      .wb_i        (wb_valid && (wb_rd == REG_ADDR_W'(r))),
      .kill_i      (kill_valid && (kill_rd == REG_ADDR_W'(r))),
      .pend_cnt_o  (pend_cnt[r]),
      .ready_cd_o  (ready_cd[r]),
      .underflow_o (entry_err[r])
    );
  end

  always_comb begin
    sb_error_d     = sb_error_q || (|entry_err);
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sb_error_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      sb_error_q     <= sb_error_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb_error     = sb_error_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// tb/tb_rv_hazard_scoreboard.sv - self-checking bench for rv_hazard_scoreboard
module tb_rv_hazard_scoreboard;
  localparam int AW       = 5;
  localparam int MAX_INF  = 2;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int SW       = 32;

  typedef struct {
    bit       valid;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit       exr;
    bit       wbv;
    bit [4:0] wbrd;
    bit       kv;
    bit [4:0] krd;
    bit       es;
    bit       ei;
    bit       ee;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic wb_valid, kill_valid;
  logic [AW-1:0] wb_rd, kill_rd;
  logic sb_error;
  logic [SW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  rv_hazard_scoreboard_if #(.REG_ADDR_W(AW)) sb_if ();

  rv_hazard_scoreboard #(
    .REG_ADDR_W   (AW),
    .MAX_INFLIGHT (MAX_INF),
    .ALU_LATENCY  (ALU_LAT),
    .LOAD_LATENCY (LOAD_LAT),
    .STAT_WIDTH   (SW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_if        (sb_if),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .kill_valid   (kill_valid),
    .kill_rd      (kill_rd),
    .sb_error     (sb_error),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: writer counts plus the absolute cycle at which the
  // youngest writer's value becomes forwardable.
  int     m_pend [32];
  longint m_ready_at [32];
  longint cyc = 0;
  bit     m_err;
  longint m_stalls;

  function automatic vec_t mk(bit valid, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit rw, bit ld, bit exr, bit wbv, bit [4:0] wbrd,
                              bit kv, bit [4:0] krd, bit es, bit ei, bit ee);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.ld = ld; v.exr = exr; v.wbv = wbv; v.wbrd = wbrd;
    v.kv = kv; v.krd = krd; v.es = es; v.ei = ei; v.ee = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at model cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 0;
      m_ready_at[r] = 0;
    end
    m_err = 0;
    m_stalls = 0;
  endtask

  function automatic bit m_stall(vec_t v);
    bit h;
    h = 0;
    if (v.u1 && v.rs1 != 0 && m_ready_at[v.rs1] > cyc) h = 1;
    if (v.u2 && v.rs2 != 0 && m_ready_at[v.rs2] > cyc) h = 1;
    if (v.rw && v.rd != 0 && m_pend[v.rd] >= MAX_INF) h = 1;
    return v.valid && h;
  endfunction

  task automatic m_step(vec_t v);
    bit st, iss;
    int n, inc, dec;
    st  = m_stall(v);
    iss = v.valid && !st && v.exr;
    for (int r = 1; r < 32; r++) begin
      inc = (iss && v.rw && v.rd == r) ? 1 : 0;
      dec = ((v.wbv && v.wbrd == r) ? 1 : 0) + ((v.kv && v.krd == r) ? 1 : 0);
      n = m_pend[r] + inc - dec;
      if (n < 0) begin
        n = 0;
        m_err = 1;
      end
      m_pend[r] = n;
      if (inc != 0) m_ready_at[r] = cyc + (v.ld ? LOAD_LAT : ALU_LAT);
      else if (v.kv && v.krd == r && n == 0) m_ready_at[r] = 0;
    end
    if (st && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    cyc++;
  endtask

  task automatic drive(vec_t v);
    sb_if.id_valid     = v.valid;
    sb_if.id_rs1       = v.rs1;
    sb_if.id_rs1_used  = v.u1;
    sb_if.id_rs2       = v.rs2;
    sb_if.id_rs2_used  = v.u2;
    sb_if.id_rd        = v.rd;
    sb_if.id_reg_write = v.rw;
    sb_if.id_is_load   = v.ld;
    sb_if.ex_ready     = v.exr;
    wb_valid           = v.wbv;
    wb_rd              = v.wbrd;
    kill_valid         = v.kv;
    kill_rd            = v.krd;
  endtask

  // Drive one cycle; check combinational outputs at negedge, registered ones after the edge.
  task automatic run_vec(vec_t v, bit has_exp, string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".stall"}, sb_if.id_stall, m_stall(v));
    chk({tag, ".issue"}, sb_if.id_issue, v.valid && !m_stall(v) && v.exr);
    if (has_exp) begin
      chk({tag, ".tbl_stall"}, sb_if.id_stall, v.es);
      chk({tag, ".tbl_issue"}, sb_if.id_issue, v.ei);
    end
    m_step(v);
    @(posedge clk);
    #1;
    chk({tag, ".sb_error"}, sb_error, m_err);
    chk({tag, ".stall_cycles"}, stall_cycles, m_stalls);
    if (has_exp) chk({tag, ".tbl_sb_error"}, sb_error, v.ee);
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   r;

  initial begin
    reset_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    @(posedge clk);
    do_reset();
    chk("reset.sb_error", sb_error, 0);
    chk("reset.stall_cycles", stall_cycles, 0);

    // load-use
    tbl.push_back(mk(1,1,1,0,0,5,1,1,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,5,1,1,1,6,1,0,1,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,5,1,1,1,6,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,5,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,6,0,0,0,0,0));
    // ALU back-to-back
    tbl.push_back(mk(1,1,1,0,0,3,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,3,1,3,1,4,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,3,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,4,0,0,0,0,0));
    // x0 and ex_ready
    tbl.push_back(mk(1,1,1,0,0,0,1,1,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,1,0,1,0,0,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,1,0,0,2,1,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,2,1,0,0,0,1,0,0,0,0,0,1,0));
    // saturation on x7
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,1,7,0,0,1,0,0));
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,1,0,0,7,1,0,1,0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,7,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,7,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,0,1,0,0,0,0));
    // kill then extra wb
    tbl.push_back(mk(1,1,1,0,0,9,1,1,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,9,1,0,0,10,1,0,1,0,0,1,9,1,0,0));
    tbl.push_back(mk(1,9,1,0,0,10,1,0,1,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,9,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,10,0,0,0,0,1));

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Reset mid-flight: load pending on x12, reset while a reader waits.
    run_vec(mk(1,1,1,0,0,12,1,1,1,0,0,0,0,0,1,1), 1'b1, "rst.lw");
    drive(mk(1,12,1,0,0,0,0,0,1,0,0,0,0,0,0,0));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    chk("rst.sb_error", sb_error, 0);
    chk("rst.stall_cycles", stall_cycles, 0);
    run_vec(mk(1,12,1,0,0,0,0,0,1,0,0,0,0,0,1,0), 1'b1, "rst.reader");
    run_vec(mk(0,0,0,0,0,0,0,0,1,1,12,0,0,0,0,1), 1'b1, "rst.wb_empty");

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 500 == 0) do_reset();
      rv = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      rv.valid = ($urandom % 4) != 0;
      rv.rs1   = 5'($urandom_range(0, 7));
      rv.u1    = $urandom % 2;
      rv.rs2   = 5'($urandom_range(0, 7));
      rv.u2    = $urandom % 2;
      rv.rd    = 5'($urandom_range(0, 7));
      rv.rw    = $urandom % 2;
      rv.ld    = $urandom % 2;
      rv.exr   = ($urandom % 4) != 0;
      r = $urandom_range(0, 7);
      rv.wbrd  = 5'(r);
      rv.wbv   = (m_pend[r] > 0) ? (($urandom % 2) == 1) : (($urandom % 60) == 0);
      r = $urandom_range(0, 7);
      rv.krd   = 5'(r);
      rv.kv    = (m_pend[r] > 0) ? (($urandom % 5) == 0) : (($urandom % 80) == 0);
      run_vec(rv, 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
